const_byte_reader: RTL and testbench
====================================

# const_byte_reader

Byte-wise readback serializer for 16-bit constant words. Accepts whole 16-bit words into a small word FIFO and streams each word out as two 8-bit bytes over a valid/ready handshake, tagging each byte with the same `byte_sel` meaning the constant register uses on its write side (1 = high byte). It sits on the return path of the 8-bit constant bus, feeding register contents back to the host/debug port.

## Interface
- `HIGH_FIRST`, 1: 1 sends high byte `[15:8]` first, then `[7:0]`; 0 sends low byte first.
- `DEPTH`, 2: word FIFO entries; power of two, ≥ 2.
- `clk`  in  1  rising-edge clock; single clock domain.
- `nreset`  in  1  reset, synchronous and active-low.
- `k_in`  in  16  word to serialize.
- `load`  in  1  write strobe; `k_in` is captured on an edge where `load && load_ready`.
- `load_ready`  out  1  FIFO not full.
- `byte_out`  out  8  current byte.
- `byte_sel`  out  1  1 = `byte_out` is `[15:8]`, 0 = `[7:0]`.
- `out_valid`  out  1  `byte_out`/`byte_sel` are valid.
- `out_ready`  in  1  consumer accepts the byte on an edge where `out_valid && out_ready`.
- `busy`  out  1  high when FIFO non-empty or a word is in flight.
- `ovf`  out  1  sticky; set by `load` while `load_ready` is low. Cleared only by reset.

## Operation
- Reset on a rising edge with `nreset` low:
  - FIFO count = 0; state = IDLE.
  - Outputs: `byte_out` = 0, `byte_sel` = 0, `out_valid` = 0, `busy` = 0, `ovf` = 0.
  - `load_ready` = 1 in the first cycle after reset.
- Reset mid-word discards the in-flight word and all FIFO contents.
- FIFO: `DEPTH` entries, pointers wrap modulo `DEPTH`, count is 0..`DEPTH`. The word being emitted is popped from the FIFO when it enters FIRST and is held in a 16-bit shadow register.
- State machine:
  - IDLE: `out_valid` = 0. If FIFO non-empty: pop into shadow, drive first byte, go to FIRST.
  - FIRST: `out_valid` = 1, first byte per `HIGH_FIRST`. On accept: drive second byte, go to SECOND.
  - SECOND: `out_valid` = 1, second byte. On accept: if FIFO non-empty (count as it stands before this edge's push), pop and drive next first byte, go to FIRST with no bubble. Otherwise go to IDLE.
- `byte_out`/`byte_sel` are registered and held stable while `out_valid && !out_ready`.
- Simultaneous push and pop on the same edge: count unchanged, both take effect.
- `load` with `load_ready` low: word dropped, FIFO unchanged, `ovf` set.
- `busy` = (count ≠ 0) || (state ≠ IDLE).

## Timing
- Load-to-output latency, empty FIFO and IDLE: word accepted at edge N is popped at edge N+1, so `out_valid` = 1 with the first byte in cycle N+1.
- Throughput: one byte per cycle with `out_ready` held high; a word takes 2 cycles; back-to-back words have no idle cycle.
- `load_ready` is registered from count: it drops the cycle after the push that fills the FIFO and rises the cycle after the pop that frees an entry.
- Data never passes combinationally from input to output.

## Test plan
- Reset, then `HIGH_FIRST` = 1, load `16'hA55A`, `out_ready` = 1:
  - cycle +1: `byte_out` = `8'hA5`, `byte_sel` = 1.
  - cycle +2: `8'h5A`, `byte_sel` = 0.
  - cycle +3: `out_valid` = 0, `busy` = 0.
- `HIGH_FIRST` = 0, load `16'h1234`: bytes `8'h34` (`byte_sel` 0) then `8'h12` (`byte_sel` 1).
- Backpressure: load `16'hBEEF`, hold `out_ready` = 0 for 5 cycles. Required: `byte_out` stays `8'hBE` with `out_valid` high throughout; `8'hEF` appears the cycle after `out_ready` rises.
- Overflow, `DEPTH` = 2, `out_ready` = 0:
  - Load `16'h0001`, `16'h0002`, `16'h0003`, `16'h0004` on consecutive cycles.
  - Required: the first word is popped into the shadow. `load_ready` falls after the third load, the fourth load is dropped, and `ovf` = 1.
  - Draining yields 00,01,00,02,00,03 with no bubbles.
- Reset mid-operation: drive `nreset` low while in SECOND with a word queued. Required next cycle: `out_valid` = 0, `busy` = 0, `ovf` = 0, `load_ready` = 1; no stale bytes emitted afterwards.
- Simultaneous push/pop: hold the FIFO at count 1 and load on the edge where SECOND is accepted. Required: count stays 1 and the byte stream continues with no gap.

Source files
------------

// File: rtl/const_byte_reader_if.sv
// Handshake bundle between a 16-bit constant word source and the byte-wide
// readback consumer. The master drives words and byte acceptance; the slave serializes.
interface const_byte_reader_if;
    logic [15:0] k_in;
    logic        load;
    logic        load_ready;
    logic [7:0]  byte_out;
    logic        byte_sel;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        ovf;

    modport master (
        output k_in, load, out_ready,
        input  load_ready, byte_out, byte_sel, out_valid, busy, ovf
    );

    modport slave (
        input  k_in, load, out_ready,
        output load_ready, byte_out, byte_sel, out_valid, busy, ovf
    );
endinterface

// File: rtl/const_byte_reader.sv
// Buffers 16-bit constant words in a small FIFO and streams each one out as two
// tagged bytes over valid/ready, back-to-back with no bubble between words.
module const_byte_reader #(
    parameter bit HIGH_FIRST = 1'b1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    const_byte_reader_if.slave    bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            load_ready_q, load_ready_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [7:0]      byte_out_q, byte_out_d;
    logic            byte_sel_q, byte_sel_d;
    logic            out_valid_q, out_valid_d;

    logic            push;
    logic            pop;
    logic            accept;
    logic            fifo_nonempty;
    logic [15:0]     head_word;

    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return HIGH_FIRST ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return HIGH_FIRST ? w[7:0] : w[15:8];
    endfunction

    assign push          = bus.load && load_ready_q;
    assign accept        = out_valid_q && bus.out_ready;
    assign fifo_nonempty = (count_q != '0);
    assign head_word     = mem_q[rd_ptr_q];

    // FIFO bookkeeping; pop decisions use the count from before this edge's push.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        load_ready_d = (count_d != CW'(DEPTH));
        ovf_d        = ovf_q || (bus.load && !load_ready_q);
    end

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        byte_out_d  = byte_out_q;
        byte_sel_d  = byte_sel_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (fifo_nonempty) begin
                    pop         = 1'b1;
                    shadow_d    = head_word;
                    byte_out_d  = first_byte(head_word);
                    byte_sel_d  = HIGH_FIRST;
                    out_valid_d = 1'b1;
                    state_d     = FIRST;
                end
            end
            FIRST: begin
                if (accept) begin
                    byte_out_d = second_byte(shadow_q);
                    byte_sel_d = !HIGH_FIRST;
                    state_d    = SECOND;
                end
            end
            SECOND: begin
                if (accept) begin
                    if (fifo_nonempty) begin
                        pop        = 1'b1;
                        shadow_d   = head_word;
                        byte_out_d = first_byte(head_word);
                        byte_sel_d = HIGH_FIRST;
                        state_d    = FIRST;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            load_ready_q <= 1'b1;
            ovf_q        <= 1'b0;
            shadow_q     <= '0;
            byte_out_q   <= '0;
            byte_sel_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            load_ready_q <= load_ready_d;
            ovf_q        <= ovf_d;
            shadow_q     <= shadow_d;
            byte_out_q   <= byte_out_d;
            byte_sel_q   <= byte_sel_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.k_in;
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.byte_out   = byte_out_q;
    assign bus.byte_sel   = byte_sel_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.ovf        = ovf_q;
    assign bus.busy       = fifo_nonempty || (state_q != IDLE);
endmodule

// File: tb/tb_const_byte_reader.sv
// Bench for const_byte_reader: high-first and low-first instances driven in lockstep,
// checked by directed scenarios and a randomized run against a word-queue model.
module tb_const_byte_reader;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        load = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] k_in = '0;

    int checks = 0;
    int passes = 0;

    // Reference model: queued words plus the word being emitted and its bytes left.
    logic [15:0] mq[$];
    logic [15:0] m_cur = '0;
    int          m_left = 0;
    bit          m_ovf = 1'b0;

    const_byte_reader_if if_hi ();
    const_byte_reader_if if_lo ();

    assign if_hi.k_in      = k_in;
    assign if_hi.load      = load;
    assign if_hi.out_ready = out_ready;
    assign if_lo.k_in      = k_in;
    assign if_lo.load      = load;
    assign if_lo.out_ready = out_ready;

    const_byte_reader #(.HIGH_FIRST(1'b1), .DEPTH(DEPTH)) u_hi (
        .clk    (clk),
        .nreset (nreset),
        .bus    (if_hi)
    );

    const_byte_reader #(.HIGH_FIRST(1'b0), .DEPTH(DEPTH)) u_lo (
        .clk    (clk),
        .nreset (nreset),
        .bus    (if_lo)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_bs(input bit hf);
        logic hi_sel;
        hi_sel = (m_left == 2) ? hf : !hf;
        return {hi_sel ? m_cur[15:8] : m_cur[7:0], hi_sel};
    endfunction

    task automatic step();
        bit          acc;
        logic [7:0]  b;
        logic        s;
        bit          m_acc;
        int          pre;
        bit          lr;
        acc = if_hi.out_valid && out_ready;
        b   = if_hi.byte_out;
        s   = if_hi.byte_sel;
        @(posedge clk);
        if (!nreset) begin
            mq.delete();
            m_left = 0;
            m_ovf  = 1'b0;
        end else begin
            m_acc = (m_left != 0) && out_ready;
            pre   = mq.size();
            lr    = (pre < DEPTH);
            if (load && !lr) m_ovf = 1'b1;
            if (pre > 0 && (m_left == 0 || (m_left == 1 && m_acc))) begin
                m_cur  = mq.pop_front();
                m_left = 2;
            end else if (m_acc) begin
                m_left = m_left - 1;
            end
            if (load && lr) mq.push_back(k_in);
            if (load) $display("t=%0t load k=%h %s", $time, k_in, lr ? "accepted" : "dropped");
            if (acc)  $display("t=%0t byte hi_inst=%h sel=%b", $time, b, s);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        nreset = 1'b0; load = 1'b0; out_ready = 1'b0; k_in = '0;
        step();
        step();
        nreset = 1'b1;
        exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if ({if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel, if_hi.busy, if_hi.ovf, if_hi.load_ready} !== exp_v)
            $display("FAIL reset_hi got=%b exp=%b", {if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel, if_hi.busy, if_hi.ovf, if_hi.load_ready}, exp_v);
        else passes++;
        checks++;
        if ({if_lo.out_valid, if_lo.byte_out, if_lo.byte_sel, if_lo.busy, if_lo.ovf, if_lo.load_ready} !== exp_v)
            $display("FAIL reset_lo got=%b exp=%b", {if_lo.out_valid, if_lo.byte_out, if_lo.byte_sel, if_lo.busy, if_lo.ovf, if_lo.load_ready}, exp_v);
        else passes++;
    endtask

    task automatic test_high_first();
        logic [9:0] seq [3];
        seq[0] = {1'b1, 8'hA5, 1'b1};
        seq[1] = {1'b1, 8'h5A, 1'b0};
        seq[2] = {1'b0, 8'h00, 1'b0};
        out_ready = 1'b1; k_in = 16'hA55A; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({if_hi.out_valid, if_hi.out_valid ? {if_hi.byte_out, if_hi.byte_sel} : 9'h0} !== seq[i])
                $display("FAIL high_first_%0d got=%b_%h_%b exp=%b", i, if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel, seq[i]);
            else passes++;
        end
        checks++;
        if (if_hi.busy !== 1'b0) $display("FAIL high_first_busy got=%b exp=0", if_hi.busy);
        else passes++;
    endtask

    task automatic test_low_first();
        logic [9:0] seq [3];
        seq[0] = {1'b1, 8'h34, 1'b0};
        seq[1] = {1'b1, 8'h12, 1'b1};
        seq[2] = {1'b0, 8'h00, 1'b0};
        out_ready = 1'b1; k_in = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({if_lo.out_valid, if_lo.out_valid ? {if_lo.byte_out, if_lo.byte_sel} : 9'h0} !== seq[i])
                $display("FAIL low_first_%0d got=%b_%h_%b exp=%b", i, if_lo.out_valid, if_lo.byte_out, if_lo.byte_sel, seq[i]);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; k_in = 16'hBEEF; load = 1'b1;
        step();
        load = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({if_hi.out_valid, if_hi.byte_out} !== {1'b1, 8'hBE})
                $display("FAIL backpressure_hold_%0d got=%b_%h exp=1_be", i, if_hi.out_valid, if_hi.byte_out);
            else passes++;
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel} !== {1'b1, 8'hEF, 1'b0})
            $display("FAIL backpressure_release got=%b_%h_%b exp=1_ef_0", if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel);
        else passes++;
        step();
        checks++;
        if (if_hi.out_valid !== 1'b0) $display("FAIL backpressure_idle got=%b exp=0", if_hi.out_valid);
        else passes++;
    endtask

    task automatic test_overflow();
        logic [7:0] seq [6];
        seq[0] = 8'h00; seq[1] = 8'h01; seq[2] = 8'h00;
        seq[3] = 8'h02; seq[4] = 8'h00; seq[5] = 8'h03;
        out_ready = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            k_in = 16'(w); load = 1'b1;
            step();
            if (w == 2) begin
                checks++;
                if (if_hi.load_ready !== 1'b1) $display("FAIL ovf_ready_after2 got=%b exp=1", if_hi.load_ready);
                else passes++;
            end
            if (w == 3) begin
                checks++;
                if ({if_hi.load_ready, if_lo.load_ready} !== 2'b00)
                    $display("FAIL ovf_ready_after3 got=%b%b exp=00", if_hi.load_ready, if_lo.load_ready);
                else passes++;
            end
        end
        load = 1'b0;
        checks++;
        if ({if_hi.ovf, if_lo.ovf} !== 2'b11) $display("FAIL ovf_sticky got=%b%b exp=11", if_hi.ovf, if_lo.ovf);
        else passes++;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({if_hi.out_valid, if_hi.byte_out} !== {1'b1, seq[i]})
                $display("FAIL ovf_drain_%0d got=%b_%h exp=1_%h", i, if_hi.out_valid, if_hi.byte_out, seq[i]);
            else passes++;
            step();
        end
        checks++;
        if ({if_hi.out_valid, if_hi.busy, if_hi.ovf} !== 3'b001)
            $display("FAIL ovf_drained got=%b%b%b exp=001", if_hi.out_valid, if_hi.busy, if_hi.ovf);
        else passes++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        k_in = 16'h1111; load = 1'b1;
        step();
        k_in = 16'h2222;
        step();
        load = 1'b0; out_ready = 1'b1;
        step();
        checks++;
        if ({if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel, if_hi.busy} !== {1'b1, 8'h11, 1'b0, 1'b1})
            $display("FAIL reset_mid_setup got=%b_%h_%b_%b exp=1_11_0_1", if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel, if_hi.busy);
        else passes++;
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        checks++;
        if ({if_hi.out_valid, if_hi.busy, if_hi.ovf, if_hi.load_ready} !== 4'b0001)
            $display("FAIL reset_mid_state got=%b%b%b%b exp=0001", if_hi.out_valid, if_hi.busy, if_hi.ovf, if_hi.load_ready);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({if_hi.out_valid, if_lo.out_valid} !== 2'b00)
                $display("FAIL reset_mid_stale_%0d got=%b%b exp=00", i, if_hi.out_valid, if_lo.out_valid);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] seq [5];
        seq[0] = {8'h44, 1'b1}; seq[1] = {8'h44, 1'b0};
        seq[2] = {8'h55, 1'b1}; seq[3] = {8'h55, 1'b0};
        out_ready = 1'b1;
        k_in = 16'h3333; load = 1'b1;
        step();
        k_in = 16'h4444;
        step();
        load = 1'b0;
        step();
        checks++;
        if ({if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel} !== {1'b1, 8'h33, 1'b0})
            $display("FAIL b2b_second got=%b_%h_%b exp=1_33_0", if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel);
        else passes++;
        k_in = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (if_hi.load_ready !== 1'b1) $display("FAIL b2b_count_held got=%b exp=1", if_hi.load_ready);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel} !== {1'b1, seq[i]})
                $display("FAIL b2b_stream_%0d got=%b_%h_%b exp=1_%h", i, if_hi.out_valid, if_hi.byte_out, if_hi.byte_sel, seq[i]);
            else passes++;
            step();
        end
        checks++;
        if ({if_hi.out_valid, if_hi.busy} !== 2'b00) $display("FAIL b2b_idle got=%b%b exp=00", if_hi.out_valid, if_hi.busy);
        else passes++;
    endtask

    task automatic test_random();
        logic [12:0] act_hi, act_lo, exp_hi, exp_lo;
        bit ev;
        for (int i = 0; i < 600; i++) begin
            k_in      = 16'($urandom);
            load      = ($urandom_range(0, 99) < 45);
            out_ready = ($urandom_range(0, 99) < 60);
            nreset    = ($urandom_range(0, 149) != 0);
            step();
            ev = (m_left != 0);
            exp_hi = {ev, ev ? exp_bs(1'b1) : 9'h0, (mq.size() < DEPTH), (mq.size() != 0 || ev), m_ovf};
            exp_lo = {ev, ev ? exp_bs(1'b0) : 9'h0, (mq.size() < DEPTH), (mq.size() != 0 || ev), m_ovf};
            act_hi = {if_hi.out_valid, if_hi.out_valid ? {if_hi.byte_out, if_hi.byte_sel} : 9'h0,
                      if_hi.load_ready, if_hi.busy, if_hi.ovf};
            act_lo = {if_lo.out_valid, if_lo.out_valid ? {if_lo.byte_out, if_lo.byte_sel} : 9'h0,
                      if_lo.load_ready, if_lo.busy, if_lo.ovf};
            checks++;
            if (act_hi !== exp_hi) $display("FAIL random_hi cyc=%0d got=%b exp=%b", i, act_hi, exp_hi);
            else passes++;
            checks++;
            if (act_lo !== exp_lo) $display("FAIL random_lo cyc=%0d got=%b exp=%b", i, act_lo, exp_lo);
            else passes++;
        end
        nreset = 1'b1; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_high_first();
        test_low_first();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
